mips_cpu_mem_ctrl: RTL and testbench
====================================

Name: mips_cpu_mem_ctrl

Overview:
- Avalon-MM bus master that sits directly downstream of the CPU control FSM in mips_cpu_bus.
- Takes one CPU-side request at a time: instruction fetch, load or store, with size byte/half/word.
- Drives the Avalon bus, holds the request through waitrequest stalls, and captures readdata the cycle after the read is accepted.
- Returns an aligned, sign- or zero-extended result, or an error for misaligned accesses.

Parameters:
- ERR_ON_MISALIGN, 1, 1: misaligned request returns resp_err without a bus cycle; 0: low address bits are forced aligned and the access proceeds.

Ports:
- clk  in  1  system clock, all state changes on posedge.
- reset  in  1  synchronous, active-low; reset==0 at a posedge resets the block.
- req_valid  in  1  CPU request strobe; sampled only while req_ready=1.
- req_ready  out  1  high in S_IDLE only.
- req_write  in  1  1=store, 0=load/fetch.
- req_size  in  2  00=byte, 01=half, 10=word, 11=reserved.
- req_signed  in  1  loads only: sign-extend byte/half when 1.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle pulse: request complete.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid: misaligned or reserved size.
- address  out  32  Avalon word address, bits[1:0] always 00.
- read  out  1  Avalon read request.
- write  out  1  Avalon write request.
- waitrequest  in  1  Avalon stall.
- writedata  out  32  Avalon write data, lane-replicated.
- byteenable  out  4  Avalon lane enables.
- readdata  in  32  Avalon read data, valid the cycle after the read is accepted.

Behaviour:
- All outputs are registered except req_ready, which decodes the state.
- Reset (reset==0 at a posedge):
  - state S_IDLE.
  - read, write, resp_valid and resp_err all 0.
  - address, writedata, byteenable and resp_rdata all 0.
  - Reset mid-transfer abandons the transfer: read/write low after that edge, no resp_valid.
- States: S_IDLE, S_REQ, S_RDATA.
- S_IDLE:
  - On req_valid, latch size, signed, write and addr[1:0].
  - Misaligned means: half with addr[0]=1, word with addr[1:0]!=0, or size=11.
  - If misaligned and ERR_ON_MISALIGN=1: next edge sets resp_valid=1, resp_err=1, resp_rdata=0; stay in S_IDLE; no bus activity.
  - Size 11 always errors, regardless of ERR_ON_MISALIGN.
  - Otherwise, next edge loads address={addr[31:2],2'b00}, byteenable, writedata, and read or write=1; go to S_REQ.
- Byteenable, little-endian:
  - word: 1111.
  - half: off0 → 0011, off2 → 1100.
  - byte: 0001 shifted left by off.
- Writedata:
  - byte: {4{wdata[7:0]}}.
  - half: {2{wdata[15:0]}}.
  - word: wdata.
- S_REQ:
  - address, byteenable, writedata and read/write are held stable while waitrequest=1. There is no timeout.
  - On an edge with waitrequest=0, deassert read/write.
  - Write: resp_valid=1, resp_err=0; go to S_IDLE.
  - Read: go to S_RDATA.
- S_RDATA:
  - Select the lane: readdata >> (8*off).
  - Extend: byte [7:0] or half [15:0], sign- or zero-extended per req_signed; word is unmodified.
  - Register the result into resp_rdata; resp_valid=1; go to S_IDLE.
- resp_valid is deasserted on every edge where it is not being set. resp_rdata and resp_err hold until the next response.
- Latency from the S_IDLE accept edge, zero wait:
  - error: resp_valid at +1.
  - write: resp_valid at +2.
  - read: resp_valid at +3.
  - Each cycle of waitrequest=1 adds one.
- Back-to-back: a new request may be accepted in the same cycle resp_valid is high (state is S_IDLE).
- read and write are never high together.
- req_* inputs are ignored outside S_IDLE.

Decomposition:
- Shared package mips_cpu_pkg holds:
  - size enum SZ_BYTE/SZ_HALF/SZ_WORD/SZ_RSVD.
  - state enum S_IDLE/S_REQ/S_RDATA.
  - the constant for the word-aligned address mask.
- One combinational sub-module, mips_cpu_mem_lanes, computes byteenable, writedata replication, misalign detection and read extraction. The FSM stays in mips_cpu_mem_ctrl.

Test Plan:
- Load word, no wait: addr=0xBFC00004, size=10, readdata=0x8C420000.
  → read=1 with address=0xBFC00004, be=1111 one cycle; resp_valid at +3; resp_rdata=0x8C420000; resp_err=0.
- Signed byte, off3, waitrequest high 3 cycles: addr=0x1003, readdata=0x80FF1234.
  → address=0x1000, be=1000 held 4 cycles; resp_rdata=0xFFFFFF80.
  → Same with req_signed=0 gives resp_rdata=0x00000080.
- Store half off2: addr=0x2002, wdata=0x0000BEEF.
  → write=1, address=0x2000, be=1100, writedata=0xBEEFBEEF; resp_valid at +2; resp_rdata=0.
- Misaligned word: addr=0x3001, size=10, ERR_ON_MISALIGN=1.
  → no read/write ever; resp_valid=1, resp_err=1 at +1.
  → Repeat with size=11 at addr=0x3000: same error.
- Reset mid-transfer: reset=0 while in S_REQ with waitrequest=1.
  → read=0 next cycle, no resp_valid; req_ready=1 after reset released.
- Back-to-back: issue a second request (load half unsigned, 0x4002, readdata=0xA5A50000) in the cycle resp_valid of the first is high.
  → accepted; resp_rdata=0x0000A5A5.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// mips_cpu_pkg: shared types and constants for the CPU memory controller.
package mips_cpu_pkg;
  typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_RSVD = 2'b11} memSize_t;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RDATA} ctrlState_t;
  localparam logic [31:0] WORD_ADDR_MASK = 32'hFFFF_FFFC;
endpackage

// File: rtl/mips_cpu_mem_lanes.sv
// mips_cpu_mem_lanes: byte-lane steering for requests and read-data extraction.
module mips_cpu_mem_lanes
  import mips_cpu_pkg::*;
(
  input  logic [1:0]  reqSize,
  input  logic [1:0]  reqOff,
  input  logic [31:0] reqWdata,
  output logic        misaligned,
  output logic [1:0]  alignedOff,
  output logic [3:0]  byteEn,
  output logic [31:0] wdataRep,
  input  logic [1:0]  rdSize,
  input  logic [1:0]  rdOff,
  input  logic        rdSigned,
  input  logic [31:0] rdata,
  output logic [31:0] rdataExt
);
  logic [31:0] shifted;
  always_comb begin
    misaligned = (reqSize == SZ_RSVD) || (reqSize == SZ_HALF && reqOff[0]) || (reqSize == SZ_WORD && reqOff != 2'b00);
    // forcing alignment here keeps lane selection correct when misalignment is tolerated
    alignedOff = reqSize == SZ_WORD ? 2'b00 : reqSize == SZ_HALF ? {reqOff[1], 1'b0} : reqOff;
    byteEn = reqSize == SZ_BYTE ? 4'b0001 << alignedOff : reqSize == SZ_HALF ? 4'b0011 << alignedOff : 4'b1111;
    wdataRep = reqSize == SZ_BYTE ? {4{reqWdata[7:0]}} : reqSize == SZ_HALF ? {2{reqWdata[15:0]}} : reqWdata;
    shifted = rdata >> {rdOff, 3'b000};
    rdataExt = rdSize == SZ_BYTE ? {{24{rdSigned & shifted[7]}}, shifted[7:0]} :
               rdSize == SZ_HALF ? {{16{rdSigned & shifted[15]}}, shifted[15:0]} : rdata;
  end
endmodule

// File: rtl/mips_cpu_mem_ctrl.sv
// mips_cpu_mem_ctrl: Avalon-MM master serving one CPU fetch/load/store at a time.
module mips_cpu_mem_ctrl
  import mips_cpu_pkg::*;
#(
  parameter bit ERR_ON_MISALIGN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  input  logic        waitrequest,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic [31:0] readdata
);
  ctrlState_t state;
  logic [1:0] sizeQ, offQ;
  logic signedQ, writeQ, misaligned, reqErr;
  logic [1:0] alignedOff;
  logic [3:0] byteEn;
  logic [31:0] wdataRep, rdataExt;
  mips_cpu_mem_lanes lanes (
    .reqSize(req_size), .reqOff(req_addr[1:0]), .reqWdata(req_wdata),
    .misaligned(misaligned), .alignedOff(alignedOff), .byteEn(byteEn), .wdataRep(wdataRep),
    .rdSize(sizeQ), .rdOff(offQ), .rdSigned(signedQ), .rdata(readdata), .rdataExt(rdataExt)
  );
  assign req_ready = state == S_IDLE;
  // reserved size can never be serviced, so it errors even when misalignment is tolerated
  assign reqErr = misaligned && (ERR_ON_MISALIGN || req_size == SZ_RSVD);
  always_ff @(posedge clk)
    if (!reset) begin
      state <= S_IDLE;
      read <= 1'b0;
      write <= 1'b0;
      resp_valid <= 1'b0;
      resp_err <= 1'b0;
      resp_rdata <= '0;
      address <= '0;
      writedata <= '0;
      byteenable <= '0;
      sizeQ <= '0;
      offQ <= '0;
      signedQ <= 1'b0;
      writeQ <= 1'b0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE:
          if (req_valid) begin
            sizeQ <= req_size;
            offQ <= alignedOff;
            signedQ <= req_signed;
            writeQ <= req_write;
            if (reqErr) begin
              resp_valid <= 1'b1;
              resp_err <= 1'b1;
              resp_rdata <= '0;
            end else begin
              address <= req_addr & WORD_ADDR_MASK;
              byteenable <= byteEn;
              writedata <= wdataRep;
              read <= !req_write;
              write <= req_write;
              state <= S_REQ;
            end
          end
        S_REQ:
          if (!waitrequest) begin
            read <= 1'b0;
            write <= 1'b0;
            if (writeQ) begin
              resp_valid <= 1'b1;
              resp_err <= 1'b0;
              resp_rdata <= '0;
              state <= S_IDLE;
            end else state <= S_RDATA;
          end
        S_RDATA: begin
          resp_rdata <= rdataExt;
          resp_valid <= 1'b1;
          resp_err <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
endmodule

// File: tb/tb_mips_cpu_mem_ctrl.sv
// tb_mips_cpu_mem_ctrl: table-driven and randomized checks of the CPU memory controller.
module tb_mips_cpu_mem_ctrl;
  logic clk = 1'b0, reset = 1'b0;
  logic req_valid = 1'b0, req_write = 1'b0, req_signed = 1'b0;
  logic [1:0] req_size = '0;
  logic [31:0] req_addr = '0, req_wdata = '0, readdata = '0;
  logic waitrequest = 1'b0;
  logic req_ready, resp_valid, resp_err, read, write;
  logic [31:0] resp_rdata, address, writedata;
  logic [3:0] byteenable;
  int nChecks = 0, nFail = 0;

  typedef struct {
    logic wr; logic [1:0] size; logic sgn;
    logic [31:0] addr, wdata, rdata; int waits;
    logic [31:0] eRdata; logic eErr; int eLat;
    logic [31:0] eAddr; logic [3:0] eBe; logic [31:0] eWd;
  } vec_t;

  mips_cpu_mem_ctrl dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err), .address(address),
    .read(read), .write(write), .waitrequest(waitrequest), .writedata(writedata),
    .byteenable(byteenable), .readdata(readdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(logic wr, logic [1:0] sz, logic sg, logic [31:0] a, logic [31:0] wd,
                              logic [31:0] rd, int w, logic [31:0] er, logic ee, int el,
                              logic [31:0] ea, logic [3:0] eb, logic [31:0] ew);
    vec_t v;
    v.wr = wr; v.size = sz; v.sgn = sg; v.addr = a; v.wdata = wd; v.rdata = rd; v.waits = w;
    v.eRdata = er; v.eErr = ee; v.eLat = el; v.eAddr = ea; v.eBe = eb; v.eWd = ew;
    return v;
  endfunction

  // reference: bytes-per-access arithmetic, lane loops and two's-complement subtraction
  function automatic vec_t model(vec_t v);
    vec_t r = v;
    int off, nb;
    logic [31:0] val;
    off = int'(v.addr[1:0]);
    r.eErr = (v.size == 2'd3) || (v.size == 2'd1 && off % 2 != 0) || (v.size == 2'd2 && off != 0);
    nb = 1 << int'(v.size);
    r.eAddr = v.addr - 32'(off);
    r.eBe = '0;
    r.eWd = '0;
    val = '0;
    if (!r.eErr) begin
      r.eBe = 4'(((1 << nb) - 1) << off);
      for (int i = 0; i < 4; i++) r.eWd[8*i +: 8] = v.wdata[8*(i % nb) +: 8];
      val = v.rdata >> (8 * off);
      if (nb < 4) begin
        val = val & ((32'd1 << (8 * nb)) - 32'd1);
        if (v.sgn && val[8*nb-1]) val = val - (32'd1 << (8 * nb));
      end
    end
    r.eRdata = (v.wr || r.eErr) ? 32'd0 : val;
    r.eLat = r.eErr ? 1 : (v.wr ? 2 : 3) + v.waits;
    return r;
  endfunction

  // drives one request in the current cycle and acts as the Avalon slave until the response
  task automatic runTxn(input vec_t v);
    int cyc = 0, busCyc = 0;
    bit got = 0, prevAcc = 0;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = v.wr; req_size = v.size; req_signed = v.sgn;
    req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk); #1;
    req_valid = 1'($urandom); req_write = 1'($urandom); req_size = 2'($urandom);
    req_signed = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
    while (!got && cyc < 40) begin
      cyc++;
      readdata = prevAcc ? v.rdata : $urandom;
      if (read || write) begin
        busCyc++;
        check("bus_rw", 32'({read, write}), v.wr ? 32'd1 : 32'd2);
        check("bus_addr", address, v.eAddr);
        check("bus_be", 32'(byteenable), 32'(v.eBe));
        if (v.wr) check("bus_wdata", writedata, v.eWd);
      end
      waitrequest = (read || write) && busCyc <= v.waits;
      prevAcc = read && !waitrequest;
      if (resp_valid) begin
        got = 1;
        check("resp_latency", 32'(cyc), 32'(v.eLat));
        check("resp_rdata", resp_rdata, v.eRdata);
        check("resp_err", 32'(resp_err), 32'(v.eErr));
        check("req_ready_resp", 32'(req_ready), 32'd1);
      end else begin
        check("req_ready_busy", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
      end
    end
    if (!got) check("resp_timeout", 32'd0, 32'd1);
    check("bus_cycles", 32'(busCyc), v.eErr ? 32'd0 : 32'(v.waits + 1));
    waitrequest = 1'b0;
    req_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    vec_t v;
    tbl.push_back(mk(0, 2'd2, 0, 32'hBFC00004, 0, 32'h8C420000, 0, 32'h8C420000, 0, 3, 32'hBFC00004, 4'hF, 0));
    tbl.push_back(mk(0, 2'd0, 1, 32'h00001003, 0, 32'h80FF1234, 3, 32'hFFFFFF80, 0, 6, 32'h00001000, 4'h8, 0));
    tbl.push_back(mk(0, 2'd0, 0, 32'h00001003, 0, 32'h80FF1234, 3, 32'h00000080, 0, 6, 32'h00001000, 4'h8, 0));
    tbl.push_back(mk(0, 2'd2, 0, 32'h00003001, 0, 32'h11111111, 0, 32'h0, 1, 1, 0, 4'h0, 0));
    tbl.push_back(mk(1, 2'd1, 0, 32'h00002002, 32'h0000BEEF, 0, 0, 32'h0, 0, 2, 32'h00002000, 4'hC, 32'hBEEFBEEF));
    tbl.push_back(mk(0, 2'd3, 0, 32'h00003000, 0, 32'h22222222, 0, 32'h0, 1, 1, 0, 4'h0, 0));
    tbl.push_back(mk(0, 2'd2, 0, 32'h00005000, 0, 32'hDEADBEEF, 1, 32'hDEADBEEF, 0, 4, 32'h00005000, 4'hF, 0));
    tbl.push_back(mk(0, 2'd1, 0, 32'h00004002, 0, 32'hA5A50000, 0, 32'h0000A5A5, 0, 3, 32'h00004000, 4'hC, 0));
    tbl.push_back(mk(1, 2'd0, 0, 32'h00006001, 32'h123456AB, 0, 1, 32'h0, 0, 3, 32'h00006000, 4'h2, 32'hABABABAB));
    tbl.push_back(mk(0, 2'd1, 1, 32'h00007000, 0, 32'h12348001, 0, 32'hFFFF8001, 0, 3, 32'h00007000, 4'h3, 0));
    tbl.push_back(mk(1, 2'd1, 0, 32'h00007001, 32'h5555AAAA, 0, 0, 32'h0, 1, 1, 0, 4'h0, 0));
    tbl.push_back(mk(1, 2'd2, 0, 32'h00008004, 32'hCAFEF00D, 0, 2, 32'h0, 0, 4, 32'h00008004, 4'hF, 32'hCAFEF00D));
    tbl.push_back(mk(0, 2'd0, 1, 32'h00009001, 0, 32'h00007F00, 0, 32'h0000007F, 0, 3, 32'h00009000, 4'h2, 0));

    repeat (3) @(posedge clk);
    #1;
    check("rst_read", 32'(read), 0);
    check("rst_write", 32'(write), 0);
    check("rst_resp_valid", 32'(resp_valid), 0);
    check("rst_resp_err", 32'(resp_err), 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_address", address, 0);
    check("rst_writedata", writedata, 0);
    check("rst_byteenable", 32'(byteenable), 0);
    check("rst_req_ready", 32'(req_ready), 1);
    reset = 1'b1;
    @(posedge clk); #1;

    // table entries run back to back: each request is presented in the previous response cycle
    foreach (tbl[i]) runTxn(tbl[i]);
    @(posedge clk); #1;
    check("resp_pulse", 32'(resp_valid), 0);

    // reset while a read is stalled
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = 32'h0000A000; waitrequest = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("mid_read_on", 32'(read), 1);
    @(posedge clk); #1;
    check("mid_read_held", 32'(read), 1);
    reset = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_read", 32'(read), 0);
    check("mid_rst_resp_valid", 32'(resp_valid), 0);
    check("mid_rst_address", address, 0);
    reset = 1'b1;
    waitrequest = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      check("post_rst_resp_valid", 32'(resp_valid), 0);
      check("post_rst_read", 32'(read), 0);
    end
    check("post_rst_ready", 32'(req_ready), 1);

    for (int n = 0; n < 300; n++) begin
      v = mk(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
             int'($urandom_range(0, 3)), 0, 0, 0, 0, 0, 0);
      if ($urandom_range(0, 2) != 0) v.addr[1:0] = 2'b00;
      runTxn(model(v));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        check("rand_resp_pulse", 32'(resp_valid), 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end
endmodule
